multicycle_control_unit: RTL

Moore-style multicycle control FSM for the 16-bit processor. It sequences the ALU / ALU-control / immediate-generator datapath through fetch, decode, execute, memory and writeback. It drives the datapath mux selects and write strobes, and waits on a memory ready handshake with timeout. It sits beside the register file and IR, taking the latched instruction and the ALU zero flag.

---
 rtl/multicycle_control_unit_pkg.sv | 118 +++++++++++
 rtl/multicycle_control_unit_mem_wait_timer.sv | 27 ++
 rtl/multicycle_control_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/multicycle_control_unit_pkg.sv
// Shared control definitions: opcodes, FSM state encodings, datapath select codes
// and the per-state control word decode used by the multicycle controller.
package control_defs;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_ALU_WB   = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_FAULT    = 4'd15
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_SI    = 4'b0101;
    localparam logic [3:0] OP_LUI   = 4'b1110;
    localparam logic [3:0] OP_LW    = 4'b0010;
    localparam logic [3:0] OP_SW    = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b1001;

    localparam logic [1:0] SRCB_BREG    = 2'b00;
    localparam logic [1:0] SRCB_TWO     = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH1 = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    typedef struct packed {
        logic       fetch;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] mem_to_reg;
        logic [1:0] pc_source;
        logic       fault;
    } ctrl_t;

    // fetch marks the state whose IRWrite/PCWrite are qualified by memory ready.
    function automatic ctrl_t ctrl_decode(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.fetch     = 1'b1;
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_TWO;
                c.alu_op    = ALUOP_ADD;
                c.pc_source = PCSRC_ALU;
            end
            ST_DECODE: begin
                c.alu_src_b = SRCB_IMM_SH1;
                c.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_BREG;
                c.alu_op    = ALUOP_FUNC;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNC;
            end
            ST_ALU_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_ALUOUT;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_ADD;
            end
            ST_MEM_RD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            ST_MEM_WB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = M2R_MDR;
            end
            ST_MEM_WR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_src_b     = SRCB_BREG;
                c.alu_op        = ALUOP_SUB;
                c.pc_write_cond = 1'b1;
                c.pc_source     = PCSRC_ALUOUT;
            end
            ST_FAULT: c.fault = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_unit_mem_wait_timer.sv
// Memory wait-state counter: counts held cycles without ready and flags when the
// count reaches MEM_TIMEOUT.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_timeout
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= 8'd0;
        end else if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_timeout = (r_count == 8'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore multicycle controller for the 16-bit processor: sequences fetch, decode,
// execute, memory and writeback, with a memory-ready timeout into a sticky fault.
module multicycle_control_unit
    import control_defs::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic [15:0] In_Inst,
    input  logic        In_Zero,
    input  logic        In_MemReady,
    output logic        Out_IRWrite,
    output logic        Out_PCWrite,
    output logic        Out_PCWriteCond,
    output logic        Out_IorD,
    output logic        Out_MemRead,
    output logic        Out_MemWrite,
    output logic        Out_RegWrite,
    output logic        Out_ALUSrcA,
    output logic [1:0]  Out_ALUSrcB,
    output logic [1:0]  Out_ALUOp,
    output logic [1:0]  Out_MemToReg,
    output logic [1:0]  Out_PCSource,
    output logic [3:0]  Out_State,
    output logic        Out_Fault,
    output logic [15:0] Out_InstCount
);

    state_t      r_state;
    state_t      w_next;
    logic        r_start;
    ctrl_t       r_ctrl;
    logic [15:0] r_inst_count;
    logic [3:0]  w_opcode;
    logic        w_wait_state;
    logic        w_tmr_en;
    logic        w_tmr_clr;
    logic        w_tmr_timeout;
    logic        w_retire;
    logic        w_unused_bits;

    assign w_opcode = In_Inst[3:0];
    // Operand fields and the zero flag are consumed by the datapath, not here.
    assign w_unused_bits = ^{In_Zero, In_Inst[15:4]};

    assign w_wait_state = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                          (r_state == ST_MEM_WR);
    assign w_tmr_en  = w_wait_state && !In_MemReady;
    assign w_tmr_clr = (w_next != r_state);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .i_clk     (CLK),
        .i_rst_n   (Reset_n),
        .i_clr     (w_tmr_clr),
        .i_en      (w_tmr_en),
        .o_timeout (w_tmr_timeout)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     w_next = r_start ? ST_FETCH : ST_IDLE;
            ST_FETCH: begin
                if (In_MemReady)        w_next = ST_DECODE;
                else if (w_tmr_timeout) w_next = ST_FAULT;
            end
            ST_DECODE: begin
                case (w_opcode)
                    OP_RTYPE:              w_next = ST_EXEC_R;
                    OP_ADDI, OP_SI, OP_LUI: w_next = ST_EXEC_I;
                    OP_LW, OP_SW:          w_next = ST_MEM_ADDR;
                    OP_BEQ:                w_next = ST_BRANCH;
                    default:               w_next = ST_FAULT;
                endcase
            end
            ST_EXEC_R:   w_next = ST_ALU_WB;
            ST_EXEC_I:   w_next = ST_ALU_WB;
            ST_ALU_WB:   w_next = ST_FETCH;
            ST_MEM_ADDR: begin
                if (w_opcode == OP_LW)      w_next = ST_MEM_RD;
                else if (w_opcode == OP_SW) w_next = ST_MEM_WR;
                else                        w_next = ST_FAULT;
            end
            ST_MEM_RD: begin
                if (In_MemReady)        w_next = ST_MEM_WB;
                else if (w_tmr_timeout) w_next = ST_FAULT;
            end
            ST_MEM_WB:   w_next = ST_FETCH;
            ST_MEM_WR: begin
                if (In_MemReady)        w_next = ST_FETCH;
                else if (w_tmr_timeout) w_next = ST_FAULT;
            end
            ST_BRANCH:   w_next = ST_FETCH;
            ST_FAULT:    w_next = ST_FAULT;
            default:     w_next = ST_FAULT;
        endcase
    end

    assign w_retire = (w_next == ST_FETCH) &&
                      ((r_state == ST_ALU_WB) || (r_state == ST_MEM_WB) ||
                       (r_state == ST_MEM_WR) || (r_state == ST_BRANCH));

    // r_start holds IDLE for one extra edge so FETCH lands on the 2nd edge after reset.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= ST_IDLE;
            r_start      <= 1'b0;
            r_ctrl       <= '0;
            r_inst_count <= 16'd0;
        end else begin
            r_state <= w_next;
            r_start <= 1'b1;
            r_ctrl  <= ctrl_decode(w_next);
            if (w_retire) begin
                r_inst_count <= r_inst_count + 16'd1;
            end
        end
    end

    assign Out_IRWrite     = r_ctrl.fetch && In_MemReady;
    assign Out_PCWrite     = r_ctrl.fetch && In_MemReady;
    assign Out_PCWriteCond = r_ctrl.pc_write_cond;
    assign Out_IorD        = r_ctrl.iord;
    assign Out_MemRead     = r_ctrl.mem_read;
    assign Out_MemWrite    = r_ctrl.mem_write;
    assign Out_RegWrite    = r_ctrl.reg_write;
    assign Out_ALUSrcA     = r_ctrl.alu_src_a;
    assign Out_ALUSrcB     = r_ctrl.alu_src_b;
    assign Out_ALUOp       = r_ctrl.alu_op;
    assign Out_MemToReg    = r_ctrl.mem_to_reg;
    assign Out_PCSource    = r_ctrl.pc_source;
    assign Out_State       = r_state;
    assign Out_Fault       = r_ctrl.fault;
    assign Out_InstCount   = r_inst_count;

endmodule
